// File: rtl/recharge_ctrl_pkg.sv
// Shared encodings and BCD digit helpers for the prepaid recharge controller.
package recharge_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_UNITS = 2'd0,
        SEL_TENS  = 2'd1,
        SEL_HUNDS = 2'd2
    } sel_e;

    localparam logic [3:0]  DISP_DASH  = 4'd10;
    localparam logic [3:0]  DISP_BLANK = 4'd11;
    localparam logic [3:0]  BCD_ZERO   = 4'd0;
    localparam logic [3:0]  BCD_NINE   = 4'd9;
    localparam logic [11:0] BCD3_ZERO  = 12'h000;
    localparam logic [11:0] BCD3_MAX   = 12'h999;

    // Returns {carry, digit}
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                 input logic ci);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        t = s - 5'd10;
        if (s > 5'd9) begin
            return {1'b1, t[3:0]};
        end else begin
            return {1'b0, s[3:0]};
        end
    endfunction

    // Returns {borrow, digit}; a negative raw difference shows up in bit 4
    function automatic logic [4:0] bcd_digit_sub(input logic [3:0] a, input logic [3:0] b,
                                                 input logic bi);
        logic [4:0] d;
        logic [4:0] t;
        d = {1'b0, a} - {1'b0, b} - {4'b0000, bi};
        t = d + 5'd10;
        if (d[4]) begin
            return {1'b1, t[3:0]};
        end else begin
            return {1'b0, d[3:0]};
        end
    endfunction

    function automatic logic [3:0] bcd_digit_inc(input logic [3:0] a);
        if (a == BCD_NINE) begin
            return BCD_ZERO;
        end else begin
            return a + 4'd1;
        end
    endfunction

endpackage

// File: rtl/recharge_ctrl_addsub.sv
// Three-digit BCD adder (saturating at 999) / subtractor with borrow flag.
module bcd3_addsub
    import recharge_ctrl_pkg::*;
(
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    input  logic        sub_i,
    output logic [11:0] res_o,
    output logic        borrow_o
);

    logic [4:0] s0_s, s1_s, s2_s;
    logic [4:0] d0_s, d1_s, d2_s;

    // Ripple both operations digit by digit and select the requested one
    always_comb begin
        s0_s = bcd_digit_add(a_i[3:0],  b_i[3:0],  1'b0);
        s1_s = bcd_digit_add(a_i[7:4],  b_i[7:4],  s0_s[4]);
        s2_s = bcd_digit_add(a_i[11:8], b_i[11:8], s1_s[4]);
        d0_s = bcd_digit_sub(a_i[3:0],  b_i[3:0],  1'b0);
        d1_s = bcd_digit_sub(a_i[7:4],  b_i[7:4],  d0_s[4]);
        d2_s = bcd_digit_sub(a_i[11:8], b_i[11:8], d1_s[4]);
        if (sub_i) begin
            res_o    = {d2_s[3:0], d1_s[3:0], d0_s[3:0]};
            borrow_o = d2_s[4];
        end else if (s2_s[4]) begin
            res_o    = BCD3_MAX;
            borrow_o = 1'b0;
        end else begin
            res_o    = {s2_s[3:0], s1_s[3:0], s0_s[3:0]};
            borrow_o = 1'b0;
        end
    end

endmodule

// File: rtl/recharge_ctrl.sv
// Prepaid balance controller: keypad entry of top-up amounts, billing deductions, display codes.
module recharge_ctrl
    import recharge_ctrl_pkg::*;
#(
    parameter int unsigned SEC_CYCLES = 100000000,
    parameter int unsigned TIMEOUT_S  = 10,
    parameter logic [11:0] BAL_INIT   = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on,
    input  logic        bt_sel,
    input  logic        bt_inc,
    input  logic        bt_ok,
    input  logic        charge_vld,
    input  logic [11:0] charge_amt,
    output logic        charge_ack,
    output logic        charge_err,
    output logic [11:0] bal,
    output logic [15:0] disp
);

    localparam int CW = $clog2(SEC_CYCLES + 1);
    localparam int SW = $clog2(TIMEOUT_S + 3);
    localparam logic [CW-1:0] CYC_ZERO      = {CW{1'b0}};
    localparam logic [CW-1:0] CYC_LAST      = CW'(SEC_CYCLES - 1);
    localparam logic [CW-1:0] CYC_HALF      = CW'(SEC_CYCLES / 2);
    localparam logic [SW-1:0] SEC_ZERO      = {SW{1'b0}};
    localparam logic [SW-1:0] SEC_TO_LAST   = SW'(TIMEOUT_S - 1);
    localparam logic [SW-1:0] SEC_DONE_LAST = SW'(1);

    state_e      state_q, state_d;
    sel_e        sel_q, sel_d;
    logic [11:0] bal_q, bal_d;
    logic [11:0] entry_q, entry_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [SW-1:0] sec_q, sec_d;
    logic        armed_q, armed_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] disp_q, disp_d;

    logic [11:0] add_b_s;
    logic        add_sub_s;
    logic [11:0] add_res_s;
    logic        add_borrow_s;
    logic [11:0] entry_inc_s;
    logic [11:0] digits_s;

    // Commit adds the entry in EDIT; everywhere else the unit subtracts the charge
    always_comb begin
        if (state_q == ST_EDIT) begin
            add_b_s   = entry_q;
            add_sub_s = 1'b0;
        end else begin
            add_b_s   = charge_amt;
            add_sub_s = 1'b1;
        end
    end

    bcd3_addsub u_addsub (
        .a_i      (bal_q),
        .b_i      (add_b_s),
        .sub_i    (add_sub_s),
        .res_o    (add_res_s),
        .borrow_o (add_borrow_s)
    );

    // Entry value with the selected digit incremented
    always_comb begin
        entry_inc_s = entry_q;
        case (sel_q)
            SEL_UNITS: entry_inc_s[3:0]  = bcd_digit_inc(entry_q[3:0]);
            SEL_TENS:  entry_inc_s[7:4]  = bcd_digit_inc(entry_q[7:4]);
            SEL_HUNDS: entry_inc_s[11:8] = bcd_digit_inc(entry_q[11:8]);
            default:   entry_inc_s = entry_q;
        endcase
    end

    // Next-state logic; the second counter restarts on every EDIT/DONE entry and button press
    always_comb begin
        state_d = state_q;
        bal_d   = bal_q;
        entry_d = entry_q;
        sel_d   = sel_q;
        armed_d = armed_q | ~charge_vld;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        if (cyc_q == CYC_LAST) begin
            cyc_d = CYC_ZERO;
            sec_d = sec_q + SW'(1);
        end else begin
            cyc_d = cyc_q + CW'(1);
            sec_d = sec_q;
        end
        if (!on) begin
            state_d = ST_IDLE;
            entry_d = BCD3_ZERO;
            sel_d   = SEL_UNITS;
            cyc_d   = CYC_ZERO;
            sec_d   = SEC_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sec_d = SEC_ZERO;
                    if (charge_vld && armed_q) begin
                        armed_d = 1'b0;
                        if (add_borrow_s) begin
                            err_d = 1'b1;
                        end else begin
                            bal_d = add_res_s;
                            ack_d = 1'b1;
                        end
                    end else if (bt_ok) begin
                        state_d = ST_EDIT;
                        entry_d = BCD3_ZERO;
                        sel_d   = SEL_UNITS;
                        cyc_d   = CYC_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EDIT: begin
                    if (bt_ok || bt_sel || bt_inc) begin
                        cyc_d = CYC_ZERO;
                        sec_d = SEC_ZERO;
                    end else begin
                        cyc_d = cyc_d;
                    end
                    if (bt_ok) begin
                        if (entry_q == BCD3_ZERO) begin
                            state_d = ST_IDLE;
                        end else begin
                            bal_d   = add_res_s;
                            state_d = ST_DONE;
                        end
                    end else if (bt_sel) begin
                        case (sel_q)
                            SEL_UNITS: sel_d = SEL_TENS;
                            SEL_TENS:  sel_d = SEL_HUNDS;
                            default:   sel_d = SEL_UNITS;
                        endcase
                    end else if (bt_inc) begin
                        entry_d = entry_inc_s;
                    end else if ((cyc_q == CYC_LAST) && (sec_q == SEC_TO_LAST)) begin
                        state_d = ST_IDLE;
                        entry_d = BCD3_ZERO;
                        sel_d   = SEL_UNITS;
                    end else begin
                        state_d = ST_EDIT;
                    end
                end
                ST_DONE: begin
                    if ((cyc_q == CYC_LAST) && (sec_q == SEC_DONE_LAST)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    entry_d = BCD3_ZERO;
                    sel_d   = SEL_UNITS;
                end
            endcase
        end
    end

    // Display codes derived from next-state values so disp tracks the state without lag
    always_comb begin
        digits_s = entry_d;
        if (!on) begin
            disp_d = {4{DISP_BLANK}};
        end else if (state_d == ST_EDIT) begin
            if (cyc_d >= CYC_HALF) begin
                case (sel_d)
                    SEL_UNITS: digits_s[3:0]  = DISP_BLANK;
                    SEL_TENS:  digits_s[7:4]  = DISP_BLANK;
                    SEL_HUNDS: digits_s[11:8] = DISP_BLANK;
                    default:   digits_s = entry_d;
                endcase
            end else begin
                digits_s = entry_d;
            end
            disp_d = {DISP_DASH, digits_s};
        end else begin
            disp_d = {DISP_BLANK, bal_d};
        end
    end

    // State and output registers; armed starts clear so a request held across reset is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bal_q   <= BAL_INIT;
            entry_q <= BCD3_ZERO;
            sel_q   <= SEL_UNITS;
            cyc_q   <= CYC_ZERO;
            sec_q   <= SEC_ZERO;
            armed_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            disp_q  <= {DISP_BLANK, BAL_INIT};
        end else begin
            state_q <= state_d;
            bal_q   <= bal_d;
            entry_q <= entry_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            sec_q   <= sec_d;
            armed_q <= armed_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            disp_q  <= disp_d;
        end
    end

    assign charge_ack = ack_q;
    assign charge_err = err_q;
    assign bal        = bal_q;
    assign disp       = disp_q;

endmodule

// File: tb/tb_recharge_ctrl.sv
// Directed bench for recharge_ctrl with a 10-cycle second and a 10 s edit timeout.
module tb_recharge_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        on = 1'b1;
    logic        bt_sel = 1'b0;
    logic        bt_inc = 1'b0;
    logic        bt_ok = 1'b0;
    logic        charge_vld = 1'b0;
    logic [11:0] charge_amt = 12'h000;
    logic        charge_ack;
    logic        charge_err;
    logic [11:0] bal;
    logic [15:0] disp;

    int vec_cnt = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    recharge_ctrl #(
        .SEC_CYCLES (10),
        .TIMEOUT_S  (10),
        .BAL_INIT   (12'h000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .on         (on),
        .bt_sel     (bt_sel),
        .bt_inc     (bt_inc),
        .bt_ok      (bt_ok),
        .charge_vld (charge_vld),
        .charge_amt (charge_amt),
        .charge_ack (charge_ack),
        .charge_err (charge_err),
        .bal        (bal),
        .disp       (disp)
    );

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_ok();
        bt_ok = 1'b1;
        tick();
        bt_ok = 1'b0;
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bt_inc = 1'b1;
            tick();
            bt_inc = 1'b0;
        end
    endtask

    task automatic press_sel(input int n);
        for (int i = 0; i < n; i++) begin
            bt_sel = 1'b1;
            tick();
            bt_sel = 1'b0;
        end
    endtask

    // Counts response pulses over n cycles
    task automatic count_resp(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (charge_ack || charge_err) cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;

        // Reset state
        wait_ticks(2);
        check_vec("rst_disp", disp, 16'hB000);
        check_vec("rst_bal", 16'(bal), 16'h0000);
        check_vec("rst_ack", 16'(charge_ack), 16'h0000);
        check_vec("rst_err", 16'(charge_err), 16'h0000);
        rst = 1'b1;
        tick();

        // Enter 023 and commit
        press_ok();
        check_vec("edit_entry", disp, 16'hA000);
        press_inc(3);
        check_vec("inc_units", disp, 16'hA003);
        press_sel(1);
        press_inc(2);
        check_vec("inc_tens", disp, 16'hA023);
        wait_ticks(5);
        check_vec("blink_off", disp, 16'hA0B3);
        wait_ticks(5);
        check_vec("blink_on", disp, 16'hA023);
        press_ok();
        check_vec("commit_bal", 16'(bal), 16'h0023);
        check_vec("done_disp", disp, 16'hB023);

        // A zero charge held during DONE is served only after the 20-cycle hold
        charge_amt = 12'h000;
        charge_vld = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            tick();
            if (charge_ack) lat = i;
        end
        check_vec("done_hold", 16'(lat), 16'd21);
        check_vec("idle_disp", disp, 16'hB023);
        charge_vld = 1'b0;
        tick();

        // Successful deduction, held request is not served twice
        charge_amt = 12'h015;
        charge_vld = 1'b1;
        tick();
        check_vec("ack_pulse", 16'(charge_ack), 16'h0001);
        check_vec("ack_noerr", 16'(charge_err), 16'h0000);
        check_vec("ded_bal", 16'(bal), 16'h0008);
        count_resp(4, cnt);
        check_vec("no_reserve", 16'(cnt), 16'd0);
        charge_vld = 1'b0;
        tick();

        // Insufficient balance
        charge_amt = 12'h009;
        charge_vld = 1'b1;
        tick();
        check_vec("err_pulse", 16'(charge_err), 16'h0001);
        check_vec("err_noack", 16'(charge_ack), 16'h0000);
        check_vec("err_bal", 16'(bal), 16'h0008);
        tick();
        check_vec("err_one", 16'(charge_err), 16'h0000);
        charge_vld = 1'b0;
        tick();

        // Enter 982 (with hundreds wrap 9->0) to reach 990
        press_ok();
        press_inc(2);
        press_sel(1);
        press_inc(8);
        press_sel(1);
        press_inc(9);
        check_vec("entry_982", disp, 16'hA982);
        press_inc(1);
        check_vec("digit_wrap", disp, 16'hA082);
        press_inc(9);
        press_ok();
        check_vec("bal_990", 16'(bal), 16'h0990);
        wait_ticks(21);

        // Selector wraps hundreds->units; 990+020 saturates
        press_ok();
        press_sel(4);
        press_inc(2);
        check_vec("sel_wrap", disp, 16'hA020);
        press_ok();
        check_vec("sat_bal", 16'(bal), 16'h0999);
        wait_ticks(21);

        // Zero entry returns straight to IDLE: a charge is then served at once
        press_ok();
        press_ok();
        charge_amt = 12'h001;
        charge_vld = 1'b1;
        tick();
        check_vec("zero_commit", 16'(charge_ack), 16'h0001);
        check_vec("bal_998", 16'(bal), 16'h0998);
        charge_vld = 1'b0;
        tick();

        // Charge and bt_ok together: charge wins, bt_ok is dropped
        charge_amt = 12'h098;
        charge_vld = 1'b1;
        bt_ok = 1'b1;
        tick();
        bt_ok = 1'b0;
        check_vec("coinc_ack", 16'(charge_ack), 16'h0001);
        check_vec("coinc_disp", disp, 16'hB900);
        charge_vld = 1'b0;
        tick();

        // Charge pending through EDIT, served the cycle after the 100-cycle timeout
        press_ok();
        charge_amt = 12'h100;
        charge_vld = 1'b1;
        count_resp(100, cnt);
        check_vec("edit_pend", 16'(cnt), 16'd0);
        check_vec("timeout_idle", disp, 16'hB900);
        tick();
        check_vec("late_ack", 16'(charge_ack), 16'h0001);
        check_vec("late_bal", 16'(bal), 16'h0800);
        charge_vld = 1'b0;
        tick();

        // Reset in the middle of entering 500 with a charge pending
        press_ok();
        press_sel(2);
        press_inc(5);
        check_vec("entry_500", disp, 16'hA500);
        charge_amt = 12'h000;
        charge_vld = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_vec("mid_rst_bal", 16'(bal), 16'h0000);
        check_vec("mid_rst_disp", disp, 16'hB000);
        wait_ticks(2);
        rst = 1'b1;
        count_resp(3, cnt);
        check_vec("post_rst_resp", 16'(cnt), 16'd0);
        charge_vld = 1'b0;
        tick();

        // Power off blanks the display, keeps the balance, suppresses charges
        press_ok();
        press_inc(5);
        press_ok();
        wait_ticks(21);
        on = 1'b0;
        tick();
        check_vec("off_disp", disp, 16'hBBBB);
        check_vec("off_bal", 16'(bal), 16'h0005);
        charge_vld = 1'b1;
        count_resp(3, cnt);
        check_vec("off_resp", 16'(cnt), 16'd0);
        charge_vld = 1'b0;
        tick();
        on = 1'b1;
        tick();
        check_vec("on_disp", disp, 16'hB005);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
